// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_pkg
// Purpose  : Shared types and helpers for the dispatch_ctrl_3 issue controller.
//            Provides opcode constants, the execution-class and FSM-state
//            enums, opcode classification and class-to-request mapping.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    // Opcode constants, instruction bits [6:0]
    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i_op = 7'b0010011;
    localparam logic [6:0] c_op_i_ld = 7'b0000011;
    localparam logic [6:0] c_op_u    = 7'b0110111;
    localparam logic [6:0] c_op_b    = 7'b1100011;
    localparam logic [6:0] c_op_j    = 7'b1101111;
    localparam logic [6:0] c_op_s    = 7'b0100011;
    localparam logic [6:0] c_op_nop  = 7'b0000000;

    typedef enum logic [1:0] {
        CLS_BR  = 2'd0,
        CLS_MEM = 2'd1,
        CLS_ALU = 2'd2
    } cls_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        ERR  = 2'd3
    } state_e;

    typedef struct packed {
        cls_e cls;
        logic legal;
    } cls_info_t;

    // Unknown opcodes come back as ALU with legal=0 so a build without the
    // illegal-op trap can dispatch them like a NOP.
    function automatic cls_info_t classify(input logic [6:0] opcode);
        cls_info_t info;
        info.cls   = CLS_ALU;
        info.legal = 1'b1;
        case (opcode)
            c_op_b, c_op_j:                     info.cls = CLS_BR;
            c_op_i_ld, c_op_s:                  info.cls = CLS_MEM;
            c_op_r, c_op_i_op, c_op_nop, c_op_u: info.cls = CLS_ALU;
            default: begin
                info.cls   = CLS_ALU;
                info.legal = 1'b0;
            end
        endcase
        return info;
    endfunction

    // Request bit order: [0]=BR/JMP [1]=LD/ST [2]=ALU/NOP
    function automatic logic [2:0] cls_onehot(input cls_e cls);
        case (cls)
            CLS_BR:  return 3'b001;
            CLS_MEM: return 3'b010;
            CLS_ALU: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_ctrl_3_ack_sync.sv
`default_nettype none
// ============================================================================
// Module   : ack_sync
// Purpose  : STAGES-deep flop chain bringing one asynchronous ack bit into the
//            clk domain. All stages reset asynchronously to 0.
// Ports    : clk   in  system clock
//            rst_n in  asynchronous active-low reset
//            d     in  asynchronous input bit
//            q     out synchronized bit (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dispatch_ctrl_3.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_ctrl_3
// Purpose  : Issue controller in front of the BR/JMP, LD/ST and ALU/NOP
//            branches. Accepts one instruction over valid/ready, classifies
//            it and runs a four-phase req/ack handshake with one branch.
//            Optional feature macro: DISPATCH_ILLEGAL_TRAP_EN (illegal opcodes
//            are accepted, flagged on illegal_op and not dispatched).
// Ports    : clk, rst_n                 clock, async active-low reset
//            in_valid/in_opcode/in_ready instruction handshake
//            req_out[2:0], ack_in[2:0]   branch handshake ([0]BR [1]MEM [2]ALU)
//            busy                        handshake in progress
//            err_timeout, err_clr        sticky timeout flag and its clear
//            illegal_op                  pulse on trapped opcode
//            cnt_br/cnt_mem/cnt_alu      completed dispatches per class
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_ctrl_3
    import dispatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [6:0]       in_opcode,
    output logic             in_ready,
    output logic [2:0]       req_out,
    input  logic [2:0]       ack_in,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_alu
);

    localparam int c_wait_w   = $clog2(TIMEOUT_CYC + 1);
    localparam int c_settle_w = $clog2(SYNC_STAGES + 1);

    // ---------------------------------------------------------------- ack sync
    logic [2:0] w_ack_s;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ack_sync
        ack_sync #(
            .STAGES (SYNC_STAGES)
        ) u_ack_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (ack_in[gi]),
            .q     (w_ack_s[gi])
        );
    end

    // The synchronizer reads 0 right after reset even if a branch is still
    // holding its ack; wait until the chain has refilled before trusting it.
    logic [c_settle_w-1:0] r_settle;
    logic                  w_settled;

    assign w_settled = (r_settle == c_settle_w'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + c_settle_w'(1);
        end
    end

    // ---------------------------------------------------------- classification
    cls_info_t w_info;
    cls_e      w_cls_in;
    logic      w_accept;
    logic      w_dispatch;
    logic      w_trap;

    assign w_info   = classify(in_opcode);
    assign w_cls_in = w_info.cls;
    assign w_accept = in_valid & in_ready;

`ifdef DISPATCH_ILLEGAL_TRAP_EN
    assign w_dispatch = w_accept & w_info.legal;
    assign w_trap     = w_accept & ~w_info.legal;
`else
    // Unknown opcodes are already steered to ALU, so every accept dispatches.
    assign w_dispatch = w_accept & (w_info.legal | (w_info.cls == CLS_ALU));
    assign w_trap     = 1'b0;
`endif

    // --------------------------------------------------------------------- FSM
    state_e                r_state;
    state_e                w_state_nxt;
    cls_e                  r_cls;
    cls_e                  w_cls_nxt;
    logic [c_wait_w-1:0]   r_wait;
    logic                  w_wait_max;
    logic                  w_sel_ack;
    logic                  w_timeout;
    logic                  w_done;

    assign w_cls_nxt  = w_dispatch ? w_cls_in : r_cls;
    assign w_sel_ack  = |(w_ack_s & cls_onehot(r_cls));
    assign w_wait_max = (r_wait == c_wait_w'(TIMEOUT_CYC - 1));

    // State register; the wait counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cls   <= CLS_ALU;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cls   <= w_cls_nxt;
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (r_state == REQ || r_state == REL) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
        end
    end

    // Next-state logic. A matching ack beats a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dispatch) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_sel_ack) begin
                    w_state_nxt = REL;
                end else if (w_wait_max) begin
                    w_state_nxt = ERR;
                    w_timeout   = 1'b1;
                end
            end
            REL: begin
                if (!w_sel_ack) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else if (w_wait_max) begin
                    w_state_nxt = ERR;
                    w_timeout   = 1'b1;
                end
            end
            ERR: begin
                if (err_clr) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    logic [2:0] w_req_nxt;
    logic       w_ready_nxt;
    logic       w_busy_nxt;

    always_comb begin
        w_req_nxt   = 3'b000;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        case (w_state_nxt)
            IDLE: w_ready_nxt = w_settled & (w_ack_s == 3'b000);
            REQ: begin
                w_req_nxt  = cls_onehot(w_cls_nxt);
                w_busy_nxt = 1'b1;
            end
            REL:     w_busy_nxt = 1'b1;
            default: w_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_out     <= 3'b000;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            req_out    <= w_req_nxt;
            in_ready   <= w_ready_nxt;
            busy       <= w_busy_nxt;
            illegal_op <= w_trap;
            if (w_timeout) begin
                err_timeout <= 1'b1;
            end else if (r_state == ERR && err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_br  <= '0;
            cnt_mem <= '0;
            cnt_alu <= '0;
        end else if (w_done) begin
            case (r_cls)
                CLS_BR:  cnt_br  <= cnt_br  + CNT_W'(1);
                CLS_MEM: cnt_mem <= cnt_mem + CNT_W'(1);
                CLS_ALU: cnt_alu <= cnt_alu + CNT_W'(1);
                default: cnt_alu <= cnt_alu;
            endcase
        end
    end

endmodule
`default_nettype wire
